div_seq_ctrl: RTL and testbench

//   Iterative restoring unsigned divider with a start/done valid-ready handshake.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 30 +++
 rtl/div_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_div_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
//   state_e : controller states (IDLE accepts, RUN iterates, DONE presents)
//   cnt_w   : width of a down-counter that must hold the value w
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem_in  : partial remainder entering the step
//   q_in    : dividend/quotient shift register; MSB is the next dividend bit
//   b       : divisor
//   rem_out : partial remainder after the trial subtraction
//   q_out   : q_in shifted left, new quotient bit in the LSB
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  // The partial remainder can have its MSB set when b is large, so the
  // shifted value keeps all of rem_in and is WIDTH+1 bits wide.
  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem_in, q_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, b});

  // After a successful subtract the result is < b, so it fits in WIDTH bits;
  // after a failed one, shifted itself is < b and fits as well.
  assign rem_out = fits ? WIDTH'(shifted - {1'b0, b}) : shifted[WIDTH-1:0];
  assign q_out   = {q_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring unsigned divider with valid/ready handshakes.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
// One quotient bit per clock in RUN; divide-by-zero short-circuits to DONE
// with quotient all-ones and remainder equal to the dividend.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;    // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (q_q),
    .b       (b_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          b_d        = divisor;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            q_d         = '1;
            rem_d       = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            q_d     = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        // cnt_q == 1 means this edge performs the final step
        if (cnt_q == CW'(1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // in_valid is deliberately not looked at here: no same-cycle accept
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomized checks for div_seq_ctrl at WIDTH=8.
module tb_div_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_chk;
  int n_err;

  div_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_quotient"},  32'(quotient),    32'd0);
    chk({tag, "_remainder"}, 32'(remainder),   32'd0);
    chk({tag, "_dbz"},       32'(div_by_zero), 32'd0);
  endtask

  // One full transaction. Called and returning at a negedge.
  // busy_iv keeps in_valid high with changing operands while the divider is
  // busy, which must not disturb the result or cause a second accept.
  // Latency is counted in rising edges after the accept edge: b!=0 needs
  // WIDTH, b==0 shows out_valid right after the accept edge itself.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit busy_iv);
    logic [7:0] eq, er;
    logic       edz;
    int         lat;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("idle_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (busy_iv) begin
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency",   32'(lat),         (b == 8'd0) ? 32'd0 : 32'(WIDTH));
    chk("quotient",  32'(quotient),    32'(eq));
    chk("remainder", 32'(remainder),   32'(er));
    chk("dbz",       32'(div_by_zero), 32'(edz));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("no_x", 32'($isunknown({in_ready, out_valid, quotient, remainder, div_by_zero})), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid",    32'(out_valid),   32'd1);
      chk("hold_q",        32'(quotient),    32'(eq));
      chk("hold_r",        32'(remainder),   32'(er));
      chk("hold_dbz",      32'(div_by_zero), 32'(edz));
      chk("hold_in_ready", 32'(in_ready),    32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready",  32'(in_ready),  32'd1);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Basic division and divide-by-zero
    do_op(8'd100, 8'd7, 0, 1'b0);
    do_op(8'd5,   8'd0, 0, 1'b0);
    // Edge values
    do_op(8'd255, 8'd1,   0, 1'b0);
    do_op(8'd3,   8'd10,  0, 1'b0);
    do_op(8'd0,   8'd0,   0, 1'b0);
    do_op(8'd255, 8'd255, 0, 1'b0);
    do_op(8'd254, 8'd255, 0, 1'b0);
    do_op(8'd255, 8'd128, 0, 1'b0);
    // Backpressure in DONE
    do_op(8'd77, 8'd9, 5, 1'b0);
    do_op(8'd42, 8'd0, 5, 1'b0);

    // Reset pulse in the middle of RUN
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_abort_valid", 32'(out_valid), 32'd0);
    do_op(8'd9, 8'd4, 0, 1'b0);

    // Randomized back-to-back ops with in_valid held high while busy
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      case (n % 4)
        0:       rb = 8'($urandom_range(0, 3));
        1:       rb = 8'($urandom_range(200, 255));
        default: rb = 8'($urandom);
      endcase
      do_op(ra, rb, n % 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
